// File: rtl/vga_pkg.sv
// Shared definitions for the host bus front end: address widths, the
// FSM state encoding and the host window decode helper.
package vga_pkg;

    localparam int HOST_ADDR_W = 11;
    localparam int VRAM_ADDR_W = 13;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RDWAIT = 3'd3,
        ST_HOLD   = 3'd4
    } hbs_state_t;

    typedef enum logic [1:0] {
        DEC_NONE = 2'd0,
        DEC_VRAM = 2'd1,
        DEC_BANK = 2'd2
    } hbs_dec_t;

    // Exactly one decode asserted selects a target; both or neither is ignored.
    function automatic hbs_dec_t decode_window(input logic vram_en_n, input logic bank_en_n);
        if (!vram_en_n && bank_en_n)
            return DEC_VRAM;
        else if (!bank_en_n && vram_en_n)
            return DEC_BANK;
        else
            return DEC_NONE;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser with a configurable reset value.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk) begin
        if (rst)
            r_sync <= {STAGES{RST_VAL}};
        else
            r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/host_bus_sync.sv
// Host bus front end: synchronises the async host strobes, waits for the
// bus to settle, issues one VRAM access per host cycle and owns the bank
// register. Optional macro BANK_READBACK_EN makes bank reads drive the bus.
//
// state  | meaning
// IDLE   | waiting for a synchronised read or write strobe
// SETTLE | strobe low, counting settle cycles before latching the bus
// ACCESS | one-cycle VRAM strobe or bank register write
// RDWAIT | capturing VRAM read data
// HOLD   | access done, waiting for both strobes to release
module host_bus_sync
    import vga_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int BANK_BITS     = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [HOST_ADDR_W-1:0]           hostBusAddr,
    input  logic [7:0]                       hostBusDataIn,
    input  logic                             nHostRMEM,
    input  logic                             nHostWMEM,
    input  logic                             nHostVRAMEn,
    input  logic                             nHostBankRegEn,
    input  logic [7:0]                       hostRdData,
    output logic [HOST_ADDR_W+BANK_BITS-1:0] hostAddr,
    output logic [7:0]                       hostWrData,
    output logic                             hostSelect,
    output logic                             hostRd,
    output logic [7:0]                       hostBusDataOut,
    output logic                             hostBusDir
);

    localparam logic [2:0] SETTLE_TC = 3'(SETTLE_CYCLES);

    logic     w_rmem_n;
    logic     w_wmem_n;
    logic     w_vram_en_n;
    logic     w_bank_en_n;
    logic     w_rd_req;
    logic     w_wr_req;
    hbs_dec_t w_dec;

    hbs_state_t                       r_state;
    logic [2:0]                       r_cnt;
    logic [HOST_ADDR_W+BANK_BITS-1:0] r_host_addr;
    logic [7:0]                       r_wr_data;
    logic                             r_rd;
    hbs_dec_t                         r_dec;
    logic [BANK_BITS-1:0]             r_bank;
    logic                             r_sel;
    logic                             r_host_rd;
    logic                             r_dir;
    logic [7:0]                       r_data_out;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rmem (
        .clk(clk), .rst(rst), .i_d(nHostRMEM), .o_q(w_rmem_n));
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wmem (
        .clk(clk), .rst(rst), .i_d(nHostWMEM), .o_q(w_wmem_n));
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_vram (
        .clk(clk), .rst(rst), .i_d(nHostVRAMEn), .o_q(w_vram_en_n));
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_bank (
        .clk(clk), .rst(rst), .i_d(nHostBankRegEn), .o_q(w_bank_en_n));

    // Both strobes low at once is not a legal bus cycle and requests nothing.
    assign w_rd_req = !w_rmem_n &&  w_wmem_n;
    assign w_wr_req = !w_wmem_n &&  w_rmem_n;
    assign w_dec    = decode_window(w_vram_en_n, w_bank_en_n);

    // Bus-cycle sequencer; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_host_addr <= '0;
            r_wr_data   <= '0;
            r_rd        <= 1'b0;
            r_dec       <= DEC_NONE;
            r_bank      <= '0;
            r_sel       <= 1'b0;
            r_host_rd   <= 1'b0;
            r_dir       <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_sel <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_req || w_wr_req) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= 3'd1;
                    end
                end
                ST_SETTLE: begin
                    if (!(w_rd_req || w_wr_req)) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == SETTLE_TC) begin
                        // Address is captured with the bank in force now, so a
                        // bank write in ACCESS cannot disturb it until HOLD ends.
                        r_host_addr <= {r_bank, hostBusAddr};
                        r_wr_data   <= hostBusDataIn;
                        r_rd        <= w_rd_req;
                        r_dec       <= w_dec;
                        r_host_rd   <= w_rd_req;
                        r_sel       <= (w_dec == DEC_VRAM);
                        r_state     <= ST_ACCESS;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_ACCESS: begin
                    if (r_dec == DEC_BANK && !r_rd)
                        r_bank <= r_wr_data[BANK_BITS-1:0];
                    if (r_dec == DEC_VRAM && r_rd) begin
                        r_dir   <= !w_rmem_n;
                        r_state <= ST_RDWAIT;
                    end
`ifdef BANK_READBACK_EN
                    else if (r_dec == DEC_BANK && r_rd) begin
                        r_dir      <= !w_rmem_n;
                        r_data_out <= {{(8-BANK_BITS){1'b0}}, r_bank};
                        r_state    <= ST_HOLD;
                    end
`endif
                    else begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_RDWAIT: begin
                    r_data_out <= hostRdData;
                    r_dir      <= !w_rmem_n;
                    r_state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    r_dir <= r_dir && !w_rmem_n;
                    if (w_rmem_n && w_wmem_n)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign hostAddr       = r_host_addr;
    assign hostWrData     = r_wr_data;
    assign hostSelect     = r_sel;
    assign hostRd         = r_host_rd;
    assign hostBusDataOut = r_data_out;
    assign hostBusDir     = r_dir;

endmodule
